// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle
// (shift-add multiply, restoring divide) behind valid/ready handshakes.
module md_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] md_data_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned DW    = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [DW-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;

  // Operand conditioning on accept: signedness per op, magnitudes, special divides.
  logic            a_sgn, b_sgn, a_neg, b_neg, b_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign a_sgn    = (md_op_i == 3'b001) || (md_op_i == 3'b010) ||
                    (md_op_i == 3'b100) || (md_op_i == 3'b110);
  assign b_sgn    = (md_op_i == 3'b001) || (md_op_i == 3'b100) || (md_op_i == 3'b110);
  assign a_neg    = a_sgn & operand_a_i[XLEN-1];
  assign b_neg    = b_sgn & operand_b_i[XLEN-1];
  assign a_mag    = a_neg ? (~operand_a_i + XLEN'(1)) : operand_a_i;
  assign b_mag    = b_neg ? (~operand_b_i + XLEN'(1)) : operand_b_i;
  assign b_zero   = (operand_b_i == '0);
  assign div_ovf  = ~md_op_i[0] && (operand_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (operand_b_i == '1);
  assign special  = md_op_i[2] && (b_zero || div_ovf);
  assign spec_res = b_zero ? (md_op_i[1] ? operand_a_i : '1)
                           : (md_op_i[1] ? '0 : operand_a_i);

  // One iteration: acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}.
  logic [XLEN:0]   mul_sum, div_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_rem;
  logic [DW-1:0]   step_next, prod_fin;
  logic [XLEN-1:0] quo, rem, res_calc;

  assign mul_sum   = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh    = acc_q[DW-1:XLEN-1];
  assign div_ge    = (div_sh >= {1'b0, opnd_q});
  assign div_rem   = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
  assign step_next = op_q[2] ? {div_rem, acc_q[XLEN-2:0], div_ge}
                             : {mul_sum, acc_q[XLEN-1:1]};
  assign prod_fin  = neg_q ? (~step_next + DW'(1)) : step_next;
  assign quo       = step_next[XLEN-1:0];
  assign rem       = step_next[DW-1:XLEN];

  always_comb begin
    res_calc = '0;
    case (op_q)
      3'b000:          res_calc = prod_fin[XLEN-1:0];
      3'b100, 3'b101:  res_calc = neg_q ? (~quo + XLEN'(1)) : quo;
      3'b110, 3'b111:  res_calc = rneg_q ? (~rem + XLEN'(1)) : rem;
      default:         res_calc = prod_fin[DW-1:XLEN];
    endcase
  end

  // Next-state and output logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_d   = md_op_i;
          cnt_d  = '0;
          neg_d  = a_neg ^ b_neg;
          rneg_d = a_neg;
          if (special) begin
            data_d  = spec_res;
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            opnd_d  = md_op_i[2] ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (md_op_i[2] ? a_mag : b_mag)};
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(XLEN - 1)) begin
          data_d  = res_calc;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      valid_d = 1'b0;
      state_d = S_IDLE;
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = valid_q;
  assign md_data_o = data_q;

endmodule
